// File: rtl/servant_irq_trace_monitor.sv
// Timer-interrupt trace monitor for the servant bench: measures entry latency,
// handler length and return PC for each interrupt and queues one record per
// completed interrupt in a show-ahead FIFO.
module servant_irq_trace_monitor #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_LAT  = 1024
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst_n,
    input  logic [31:0]                pc_adr,
    input  logic                       pc_vld,
    input  logic                       timer_irq,
    input  logic                       mret,
    input  logic                       isjump,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic [2*CNT_W+31:0]        rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic                       overflow,
    output logic                       err_tmo,
    output logic [15:0]                irq_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = 2 * CNT_W + 32;
    localparam logic [CNT_W-1:0] LAT_LIM = CNT_W'(MAX_LAT);
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VEC,
        S_IN_HND,
        S_WAIT_RET
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              irq_q;
    logic              irq_edge;
    logic              vec_hit;
    logic              start;
    logic              hit;
    logic              tmo;
    logic              push_req;
    logic [CNT_W-1:0]  lat;
    logic [CNT_W-1:0]  hnd;

    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // isjump is part of the observed bus but handler-internal jumps never change state
    logic              unused_isjump;
    assign unused_isjump = isjump;

    assign irq_edge = timer_irq & ~irq_q;
    assign vec_hit  = pc_vld && (pc_adr == TRAP_VEC);

    // irq_q keeps sampling during reset so a level already high at release is not an edge
    always_ff @(posedge wb_clk) begin
        irq_q <= timer_irq;
    end

    // FSM state register
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-cycle event strobes
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        hit      = 1'b0;
        tmo      = 1'b0;
        push_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (irq_edge) begin
                    start    = 1'b1;
                    state_nx = S_WAIT_VEC;
                end
            end
            S_WAIT_VEC: begin
                if (vec_hit) begin
                    hit      = 1'b1;
                    state_nx = S_IN_HND;
                end else if (lat == LAT_LIM) begin
                    tmo      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_IN_HND: begin
                if (mret) begin
                    state_nx = S_WAIT_RET;
                end
            end
            S_WAIT_RET: begin
                if (pc_vld) begin
                    push_req = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Latency / handler counters, interrupt count and timeout flag
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            lat     <= '0;
            hnd     <= '0;
            irq_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            if (start) begin
                lat     <= CNT_W'(1);
                irq_cnt <= irq_cnt + 16'd1;
            end else if (state == S_WAIT_VEC && !hit && !tmo) begin
                lat <= lat + CNT_W'(1);
            end

            if (hit) begin
                hnd <= CNT_W'(1);
            end else if (state == S_IN_HND && !mret && hnd != '1) begin
                hnd <= hnd + CNT_W'(1);
            end

            if (tmo) begin
                err_tmo <= 1'b1;
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign pop     = rd_en & ~empty;
    // a full FIFO still takes the record when the same cycle frees a slot
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge wb_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {pc_adr, hnd, lat};
        end
    end

    assign rd_vld  = ~empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign busy    = (state != S_IDLE);

endmodule
